// File: rtl/zoom_pkg.sv
// Shared definitions for the zoom coprocessor and its command issuer:
// opcodes, image geometry, response status bit positions, issuer states.
package zoom_pkg;

    // Image geometry
    localparam int IMG_W      = 320;
    localparam int IMG_H      = 240;
    localparam int IMG_PIXELS = IMG_W * IMG_H;
    localparam int ADDR_W     = 17;

    // Coprocessor instruction opcodes
    localparam logic [2:0] NOP         = 3'd0;
    localparam logic [2:0] LOAD        = 3'd1;
    localparam logic [2:0] STORE       = 3'd2;
    localparam logic [2:0] ZOOM_IN_VP  = 3'd3;
    localparam logic [2:0] ZOOM_IN_RP  = 3'd4;
    localparam logic [2:0] ZOOM_OUT_MP = 3'd5;
    localparam logic [2:0] ZOOM_OUT_VD = 3'd6;
    localparam logic [2:0] RESET_INST  = 3'd7;

    // Response status bit positions
    localparam int STATUS_W    = 4;
    localparam int ST_ERROR    = 0;
    localparam int ST_ZOOM_MIN = 1;
    localparam int ST_ZOOM_MAX = 2;
    localparam int ST_TIMEOUT  = 3;

    // Issuer state machine
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_READY,
        S_SETUP,
        S_PULSE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_RESPOND
    } issuer_state_t;

    // Largest of four cycle counts; sizes the shared phase counter
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for asynchronous status inputs. Every bit goes
// through the same number of stages so bits that change together arrive
// together.
module bit_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    // Shift the input through the flop chain
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/zoom_cmd_issuer.sv
// Command issuer for the zoom coprocessor instruction port. Takes one host
// command at a time, drives instruction/address/data, generates the active-low
// enable pulse, tracks the FLAG_DONE handshake and returns a held response.
module zoom_cmd_issuer
    import zoom_pkg::*;
#(
    parameter int SYNC_STAGES       = 2,
    parameter int SETUP_CYCLES      = 2,
    parameter int ENABLE_LOW_CYCLES = 4,
    parameter int ACK_TIMEOUT       = 32,
    parameter int DONE_TIMEOUT      = 1048576
) (
    input  logic        clock,
    input  logic        reset_n,
    // host command
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_opcode,
    input  logic [16:0] cmd_addr,
    input  logic [7:0]  cmd_data,
    // host response
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic [3:0]  rsp_status,
    // coprocessor instruction port
    output logic [2:0]  cp_instruction,
    output logic [16:0] cp_mem_addr,
    output logic [7:0]  cp_data_in,
    output logic        cp_enable_n,
    input  logic [7:0]  cp_data_out,
    input  logic        cp_done,
    input  logic        cp_error,
    input  logic        cp_zoom_max,
    input  logic        cp_zoom_min,
    output logic        busy
);

    localparam int MAX_CYC = max4(SETUP_CYCLES, ENABLE_LOW_CYCLES, ACK_TIMEOUT, DONE_TIMEOUT);
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int SYNC_W  = 12;

    // Last counter value of each timed phase; a zero count still spends one cycle
    localparam logic [CNT_W-1:0] SETUP_END = CNT_W'((SETUP_CYCLES      > 0) ? SETUP_CYCLES      - 1 : 0);
    localparam logic [CNT_W-1:0] ENA_END   = CNT_W'((ENABLE_LOW_CYCLES > 0) ? ENABLE_LOW_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] ACK_END   = CNT_W'((ACK_TIMEOUT       > 0) ? ACK_TIMEOUT       - 1 : 0);
    localparam logic [CNT_W-1:0] DONE_END  = CNT_W'((DONE_TIMEOUT      > 0) ? DONE_TIMEOUT      - 1 : 0);

    issuer_state_t     state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [SYNC_W-1:0] sync_in, sync_out;
    logic              done_s, error_s, zoom_max_s, zoom_min_s;
    logic [7:0]        data_s;
    logic              accept;
    logic              ack_expired, done_expired;

    // Status inputs share one synchroniser so flags stay aligned with done
    assign sync_in = {cp_data_out, cp_zoom_min, cp_zoom_max, cp_error, cp_done};

    bit_sync #(
        .WIDTH  (SYNC_W),
        .STAGES (SYNC_STAGES)
    ) u_status_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (sync_in),
        .dout    (sync_out)
    );

    assign done_s     = sync_out[0];
    assign error_s    = sync_out[1];
    assign zoom_max_s = sync_out[2];
    assign zoom_min_s = sync_out[3];
    assign data_s     = sync_out[11:4];

    assign cmd_ready    = (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign accept       = cmd_valid && cmd_ready;
    assign ack_expired  = (cnt >= ACK_END);
    assign done_expired = (cnt >= DONE_END);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (cmd_opcode == NOP) ? S_RESPOND : S_WAIT_READY;
                end
            end
            S_WAIT_READY: begin
                // never trigger a coprocessor that is still busy
                if (done_s) state_nxt = S_SETUP;
            end
            S_SETUP: begin
                if (cnt >= SETUP_END) state_nxt = S_PULSE;
            end
            S_PULSE: begin
                if (cnt >= ENA_END) state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (!done_s)          state_nxt = S_WAIT_DONE;
                else if (ack_expired) state_nxt = S_RESPOND;
            end
            S_WAIT_DONE: begin
                if (done_s || done_expired) state_nxt = S_RESPOND;
            end
            S_RESPOND: begin
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Phase counter: cleared on every state change, saturates instead of wrapping
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Enable is low exactly while in PULSE; rsp_valid exactly while in RESPOND
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cp_enable_n <= 1'b1;
            rsp_valid   <= 1'b0;
        end else begin
            cp_enable_n <= (state_nxt != S_PULSE);
            rsp_valid   <= (state_nxt == S_RESPOND);
        end
    end

    // Command capture and response data/status
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cp_instruction <= '0;
            cp_mem_addr    <= '0;
            cp_data_in     <= '0;
            rsp_data       <= '0;
            rsp_status     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        // address is passed through unchecked
                        cp_instruction <= cmd_opcode;
                        cp_mem_addr    <= cmd_addr;
                        cp_data_in     <= cmd_data;
                        rsp_data       <= '0;
                        rsp_status     <= '0;
                    end
                end
                S_WAIT_ACK: begin
                    // RESET never lowers done, so a missing ack is normal for it
                    if (done_s && ack_expired && (cp_instruction != RESET_INST)) begin
                        rsp_status[ST_TIMEOUT] <= 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (done_s) begin
                        rsp_status[ST_TIMEOUT]  <= 1'b0;
                        rsp_status[ST_ZOOM_MAX] <= zoom_max_s;
                        rsp_status[ST_ZOOM_MIN] <= zoom_min_s;
                        rsp_status[ST_ERROR]    <= error_s;
                        if (cp_instruction == LOAD) rsp_data <= data_s;
                    end else if (done_expired) begin
                        rsp_status             <= '0;
                        rsp_status[ST_TIMEOUT] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_zoom_cmd_issuer.sv
// Bench for zoom_cmd_issuer: behavioural coprocessor model, directed vector
// table, randomized commands against a reference model, and hand sequences
// for NOP latency, response hold, simultaneous handshake and mid-pulse reset.
module tb_zoom_cmd_issuer;
    import zoom_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [2:0]  cmd_opcode = '0;
    logic [16:0] cmd_addr = '0;
    logic [7:0]  cmd_data = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [7:0]  rsp_data;
    logic [3:0]  rsp_status;
    logic [2:0]  cp_instruction;
    logic [16:0] cp_mem_addr;
    logic [7:0]  cp_data_in;
    logic        cp_enable_n;
    logic [7:0]  cp_data_out = '0;
    logic        cp_done;
    logic        cp_error = 1'b0, cp_zoom_max = 1'b0, cp_zoom_min = 1'b0;
    logic        busy;

    always #5 clock = ~clock;

    zoom_cmd_issuer dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
        .cp_instruction(cp_instruction), .cp_mem_addr(cp_mem_addr), .cp_data_in(cp_data_in),
        .cp_enable_n(cp_enable_n), .cp_data_out(cp_data_out), .cp_done(cp_done),
        .cp_error(cp_error), .cp_zoom_max(cp_zoom_max), .cp_zoom_min(cp_zoom_min),
        .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- coprocessor model ----------------
    // cfg_flags: [0]=error [1]=zoom_min [2]=zoom_max reported at completion
    int          cyc = 0;
    int          busy_until = 0;
    int          cfg_lat = 20;
    bit          cfg_ignore = 1'b0;
    logic [2:0]  cfg_flags = '0;
    bit          op_act = 1'b0;
    int          op_end = 0;
    logic [2:0]  m_op = '0;
    logic [16:0] m_addr = '0;
    logic [7:0]  m_data = '0;
    logic [7:0]  cp_mem [int];
    int          pulses = 0, low_run = 0, last_width = 0, fall_cyc = 0;
    logic [16:0] fall_addr = '0;
    logic        fall_done = 1'b0;
    logic        en_q = 1'b1;

    // unwritten pixels read back as a fixed function of the address
    function automatic logic [7:0] dflt(input logic [16:0] a);
        return 8'((32'(a) * 7 + 32'h35) & 32'hFF);
    endfunction

    assign cp_done = (cyc >= busy_until) && !op_act;

    always @(posedge clock) begin
        cyc     <= cyc + 1;
        en_q    <= cp_enable_n;
        low_run <= cp_enable_n ? 0 : low_run + 1;
        if (en_q && !cp_enable_n) begin
            pulses    <= pulses + 1;
            fall_addr <= cp_mem_addr;
            fall_cyc  <= cyc;
            fall_done <= cp_done;
            if (!cfg_ignore && cp_instruction != RESET_INST) begin
                op_act <= 1'b1;
                op_end <= cyc + cfg_lat;
                m_op   <= cp_instruction;
                m_addr <= cp_mem_addr;
                m_data <= cp_data_in;
            end
        end
        if (!en_q && cp_enable_n) last_width <= low_run;
        if (op_act && cyc >= op_end) begin
            op_act      <= 1'b0;
            cp_error    <= cfg_flags[0];
            cp_zoom_min <= cfg_flags[1];
            cp_zoom_max <= cfg_flags[2];
            if (m_op == LOAD) begin
                if (m_addr < IMG_PIXELS)
                    cp_data_out <= cp_mem.exists(int'(m_addr)) ? cp_mem[int'(m_addr)] : dflt(m_addr);
                else
                    cp_data_out <= 8'h00;
            end else begin
                cp_data_out <= 8'h3C;
            end
            if (m_op == STORE && m_addr < IMG_PIXELS) cp_mem[int'(m_addr)] = m_data;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [int];

    task automatic ref_exp(input logic [2:0] op, input logic [16:0] a, input logic [7:0] d,
                           input logic [2:0] fl, output logic [7:0] ed, output logic [3:0] es,
                           output int ep);
        logic [3:0] st;
        st = '0;
        st[ST_ERROR]    = fl[0];
        st[ST_ZOOM_MIN] = fl[1];
        st[ST_ZOOM_MAX] = fl[2];
        ed = 8'h00; es = 4'h0; ep = 1;
        if (op == NOP) begin
            ep = 0;
        end else if (op == RESET_INST) begin
            es = 4'h0;
        end else if (op == LOAD) begin
            es = st;
            if (a < IMG_PIXELS) ed = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
        end else begin
            es = st;
            if (op == STORE && a < IMG_PIXELS) ref_mem[int'(a)] = d;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [16:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output logic [3:0] rs, output logic got);
        int n;
        n = 0;
        @(negedge clock);
        while (!cmd_ready && n < 200) begin @(negedge clock); n++; end
        cmd_valid = 1'b1; cmd_opcode = op; cmd_addr = a; cmd_data = d;
        @(negedge clock);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 3000) begin @(negedge clock); n++; end
        got = rsp_valid; rd = rsp_data; rs = rsp_status;
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [2:0] op, input logic [16:0] a,
                           input logic [7:0] d, input int lat, input logic [2:0] fl,
                           input int pre, input bit ign, input logic [7:0] ed,
                           input logic [3:0] es, input int ep);
        int p0;
        logic [7:0] rd;
        logic [3:0] rs;
        logic got;
        cfg_lat = lat; cfg_flags = fl; cfg_ignore = ign;
        busy_until = cyc + pre;
        if (pre > 0) repeat (4) @(negedge clock);
        p0 = pulses;
        do_cmd(op, a, d, rd, rs, got);
        repeat (2) @(negedge clock);
        chk({tag, "_rsp"}, 32'(got), 32'd1);
        chk({tag, "_data"}, 32'(rd), 32'(ed));
        chk({tag, "_status"}, 32'(rs), 32'(es));
        chk({tag, "_pulses"}, 32'(pulses - p0), 32'(ep));
        if (ep == 1) begin
            chk({tag, "_width"}, 32'(last_width), 32'd4);
            chk({tag, "_addr"}, 32'(fall_addr), 32'(a));
            chk({tag, "_idle_at_trig"}, 32'(fall_done), 32'd1);
            chk({tag, "_after_busy"}, 32'(fall_cyc >= busy_until), 32'd1);
        end
        cfg_ignore = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [16:0] addr;
        logic [7:0]  data;
        int          lat;
        logic [2:0]  flags;
        int          pre;
        bit          ign;
        logic [7:0]  exp_d;
        logic [3:0]  exp_s;
        int          exp_p;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ed;
        logic [3:0] es;
        int ep, n;
        bit stable;
        logic [2:0]  rop;
        logic [16:0] ra;
        logic [7:0]  rdat;
        logic [2:0]  rfl;

        vecs[0] = '{LOAD,        17'h00010, 8'h00, 40, 3'b000,   0, 1'b0, 8'hA5, 4'b0000, 1};
        vecs[1] = '{STORE,       17'd76799, 8'h1C, 20, 3'b000, 100, 1'b0, 8'h00, 4'b0000, 1};
        vecs[2] = '{ZOOM_IN_VP,  17'd5,     8'h00, 30, 3'b100,   0, 1'b0, 8'h00, 4'b0100, 1};
        vecs[3] = '{RESET_INST,  17'd0,     8'h00, 20, 3'b000,   0, 1'b0, 8'h00, 4'b0000, 1};
        vecs[4] = '{STORE,       17'd100,   8'h77, 20, 3'b000,   0, 1'b1, 8'h00, 4'b1000, 1};
        vecs[5] = '{LOAD,        17'd76799, 8'h00, 15, 3'b000,   0, 1'b0, 8'h1C, 4'b0000, 1};
        vecs[6] = '{ZOOM_OUT_VD, 17'd9,     8'h00, 25, 3'b001,   0, 1'b0, 8'h00, 4'b0001, 1};
        vecs[7] = '{ZOOM_IN_RP,  17'd9,     8'h00, 12, 3'b010,  10, 1'b0, 8'h00, 4'b0010, 1};
        vecs[8] = '{LOAD,        17'h1FFFF, 8'h00, 18, 3'b000,   0, 1'b0, 8'h00, 4'b0000, 1};
        vecs[9] = '{NOP,         17'd3,     8'h55, 20, 3'b111,   0, 1'b0, 8'h00, 4'b0000, 0};

        // reset state
        #12;
        chk("rst_enable_n", 32'(cp_enable_n), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_status", 32'(rsp_status), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cp_regs", 32'({cp_instruction, cp_mem_addr, cp_data_in}), 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        // directed table; ref model tracks memory effects of the stores
        for (int i = 0; i < 10; i++) begin
            ref_exp(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].flags, ed, es, ep);
            run_one($sformatf("v%0d", i), vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].lat,
                    vecs[i].flags, vecs[i].pre, vecs[i].ign, vecs[i].exp_d, vecs[i].exp_s,
                    vecs[i].exp_p);
        end

        // NOP latency and held response
        @(negedge clock);
        n = pulses;
        cmd_valid = 1'b1; cmd_opcode = NOP; cmd_addr = 17'd1; cmd_data = 8'hFF;
        chk("nop_rv_before", 32'(rsp_valid), 32'd0);
        @(negedge clock);
        cmd_valid = 1'b0;
        chk("nop_rv_next", 32'(rsp_valid), 32'd1);
        chk("nop_cmd_ready", 32'(cmd_ready), 32'd0);
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (!(rsp_valid === 1'b1 && rsp_data === 8'h00 && rsp_status === 4'h0 && cmd_ready === 1'b0))
                stable = 1'b0;
        end
        chk("nop_hold_stable", 32'(stable), 32'd1);
        // simultaneous rsp_ready and cmd_valid: command waits for IDLE
        rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_opcode = NOP;
        @(negedge clock);
        rsp_ready = 1'b0;
        chk("simul_rv_cleared", 32'(rsp_valid), 32'd0);
        chk("simul_idle", 32'({busy, cmd_ready}), 32'b01);
        @(negedge clock);
        cmd_valid = 1'b0;
        chk("simul_accept_next", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        chk("nop_no_pulse", 32'(pulses - n), 32'd0);

        // asynchronous reset in the middle of the enable pulse
        cfg_lat = 40; cfg_flags = 3'b000;
        @(negedge clock);
        cmd_valid = 1'b1; cmd_opcode = LOAD; cmd_addr = 17'h20; cmd_data = 8'h00;
        @(negedge clock);
        cmd_valid = 1'b0;
        n = 0;
        while (cp_enable_n && n < 200) begin @(negedge clock); n++; end
        chk("rst_mid_reach_pulse", 32'(cp_enable_n), 32'd0);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_enable_n", 32'(cp_enable_n), 32'd1);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (100) @(negedge clock);
        chk("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
        run_one("post_rst_load", LOAD, 17'h20, 8'h00, 40, 3'b000, 0, 1'b0, 8'h15, 4'b0000, 1);

        // randomized commands against the reference model
        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0:       ra = 17'($urandom_range(IMG_PIXELS, 131071));
                1, 2, 3: ra = 17'($urandom_range(0, 15));
                default: ra = 17'($urandom_range(0, IMG_PIXELS - 1));
            endcase
            rdat = 8'($urandom);
            rfl  = 3'($urandom);
            ref_exp(rop, ra, rdat, rfl, ed, es, ep);
            run_one($sformatf("r%0d_op%0d", i, rop), rop, ra, rdat, $urandom_range(10, 60), rfl,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0, 1'b0, ed, es, ep);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
